// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between N requesters and the priority_arbiter.
//   req         requester -> arbiter, one bit per requester
//   rr_mode     requester -> arbiter, 0 = fixed priority, 1 = round-robin
//   grant       arbiter -> requester, one-hot grant (zero when idle)
//   grant_idx   arbiter -> requester, binary index of the grant (0 when idle)
//   grant_valid arbiter -> requester, high while a grant is held
//   forced_rel  arbiter -> requester, one-cycle pulse on a hold-limit revocation
interface priority_arbiter_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned IDX_W = $clog2(N);

    logic [N-1:0]     req;
    logic             rr_mode;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             forced_rel;

    modport master (
        output req, rr_mode,
        input  grant, grant_idx, grant_valid, forced_rel
    );

    modport slave (
        input  req, rr_mode,
        output grant, grant_idx, grant_valid, forced_rel
    );
endinterface

// File: rtl/priority_arbiter_prio_pick.sv
// Combinational winner search over N request lines.
//   req_i   request vector
//   start_i index searched first; search continues downward, wrapping 0 -> N-1
//   win_o   index of the first set request found (0 when none)
//   any_o   high when at least one request is set
module priority_arbiter_prio_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [IDX_W-1:0] win_o,
    output logic             any_o
);

    always_comb begin
        int idx;
        win_o = '0;
        any_o = 1'b0;
        idx   = 0;
        for (int k = 0; k < int'(N); k++) begin
            idx = int'(start_i) - k;
            if (idx < 0) begin
                idx = idx + int'(N);
            end
            // First hit wins; later hits are lower in the rotated order.
            if (!any_o && req_i[idx]) begin
                any_o = 1'b1;
                win_o = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/priority_arbiter.sv
// Registered N-request arbiter with fixed-priority (highest index wins) or
// round-robin selection, grant locking and an optional hold limit.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   arb_io request/grant bundle (slave side), see priority_arbiter_if
module priority_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    priority_arbiter_if.slave       arb_io
);

    localparam int unsigned      IDX_W   = $clog2(N);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);
    localparam logic [7:0]       HoldMax = 8'(MAX_HOLD);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             forced_q, forced_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [7:0]       hold_q, hold_d;
    // Mode captured at arbitration; decides whether the release moves ptr.
    logic             mode_q, mode_d;

    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] win;
    logic             any_req;
    logic             hold_limit;

    assign start = arb_io.rr_mode ? ptr_q : LastIdx;

    priority_arbiter_prio_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (arb_io.req),
        .start_i (start),
        .win_o   (win),
        .any_o   (any_req)
    );

    assign hold_limit = (MAX_HOLD != 0) && (hold_q == HoldMax);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        forced_d = 1'b0;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        mode_d   = mode_q;
        unique case (state_q)
            StIdle: begin
                grant_d = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                hold_d  = '0;
                if (any_req) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    idx_d        = win;
                    valid_d      = 1'b1;
                    hold_d       = 8'd1;
                    mode_d       = arb_io.rr_mode;
                    state_d      = StGrant;
                end
            end
            StGrant: begin
                // Voluntary release takes precedence over the hold limit.
                if (!arb_io.req[idx_q] || hold_limit) begin
                    grant_d  = '0;
                    idx_d    = '0;
                    valid_d  = 1'b0;
                    hold_d   = '0;
                    forced_d = arb_io.req[idx_q];
                    state_d  = StIdle;
                    if (mode_q) begin
                        ptr_d = (idx_q == '0) ? LastIdx : idx_q - 1'b1;
                    end
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            forced_q <= 1'b0;
            ptr_q    <= LastIdx;
            hold_q   <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            forced_q <= forced_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            mode_q   <= mode_d;
        end
    end

    assign arb_io.grant       = grant_q;
    assign arb_io.grant_idx   = idx_q;
    assign arb_io.grant_valid = valid_q;
    assign arb_io.forced_rel  = forced_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed bench: DUT "a" uses MAX_HOLD=8, DUT "b" uses MAX_HOLD=2, both N=4.
module tb_priority_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    priority_arbiter_if #(.N(4)) a_if ();
    priority_arbiter_if #(.N(4)) b_if ();

    priority_arbiter #(.N(4), .MAX_HOLD(8)) u_dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_io (a_if)
    );

    priority_arbiter #(.N(4), .MAX_HOLD(2)) u_dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_io (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Invariants sampled on every falling edge.
    always @(negedge clk) begin
        check_eq("a_onehot", 32'($onehot0(a_if.grant)), 32'd1);
        check_eq("a_valid_eq_or", 32'(a_if.grant_valid), 32'(|a_if.grant));
        check_eq("b_onehot", 32'($onehot0(b_if.grant)), 32'd1);
        check_eq("b_valid_eq_or", 32'(b_if.grant_valid), 32'(|b_if.grant));
    end

    initial begin
        int rr_order [5] = '{3, 2, 1, 0, 3};
        n_checks = 0;
        n_errors = 0;
        rst_n      = 1'b0;
        a_if.req     = '0;
        a_if.rr_mode = 1'b0;
        b_if.req     = '0;
        b_if.rr_mode = 1'b0;

        // Reset state
        tick();
        check_eq("rst_grant", 32'(a_if.grant), 32'h0);
        check_eq("rst_idx", 32'(a_if.grant_idx), 32'h0);
        check_eq("rst_valid", 32'(a_if.grant_valid), 32'h0);
        check_eq("rst_forced", 32'(a_if.forced_rel), 32'h0);
        rst_n = 1'b1;
        tick();

        // Fixed mode, single grant then voluntary release
        a_if.req = 4'b0110;
        tick();
        check_eq("fx_grant", 32'(a_if.grant), 32'h4);
        check_eq("fx_idx", 32'(a_if.grant_idx), 32'd2);
        check_eq("fx_valid", 32'(a_if.grant_valid), 32'd1);
        a_if.req = 4'b0010;
        tick();
        check_eq("fx_rel_grant", 32'(a_if.grant), 32'h0);
        check_eq("fx_rel_forced", 32'(a_if.forced_rel), 32'h0);
        a_if.req = 4'b0000;
        tick();
        check_eq("fx_idle_grant", 32'(a_if.grant), 32'h0);

        // Fixed mode, all requesting, hold limit 8
        a_if.req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("hold8_grant", 32'(a_if.grant), 32'h8);
            check_eq("hold8_noforce", 32'(a_if.forced_rel), 32'h0);
        end
        tick();
        check_eq("hold8_forced", 32'(a_if.forced_rel), 32'h1);
        check_eq("hold8_bubble", 32'(a_if.grant), 32'h0);
        tick();
        check_eq("hold8_regrant", 32'(a_if.grant), 32'h8);
        check_eq("hold8_pulse_end", 32'(a_if.forced_rel), 32'h0);
        a_if.req = 4'b0000;
        tick();
        check_eq("hold8_vol_forced", 32'(a_if.forced_rel), 32'h0);
        tick();

        // Round-robin, hold limit 2: order 3,2,1,0,3
        b_if.rr_mode = 1'b1;
        b_if.req     = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("rr_idx_c1", 32'(b_if.grant_idx), 32'(rr_order[i]));
            check_eq("rr_valid_c1", 32'(b_if.grant_valid), 32'd1);
            tick();
            check_eq("rr_idx_c2", 32'(b_if.grant_idx), 32'(rr_order[i]));
            tick();
            check_eq("rr_forced", 32'(b_if.forced_rel), 32'd1);
            check_eq("rr_rel_valid", 32'(b_if.grant_valid), 32'd0);
        end
        b_if.req = 4'b0000;
        tick();

        // Round-robin wrap: grant 0, release, then 1001 picks 3
        b_if.req = 4'b0001;
        tick();
        check_eq("wrap_idx0", 32'(b_if.grant_idx), 32'd0);
        check_eq("wrap_grant0", 32'(b_if.grant), 32'h1);
        b_if.req = 4'b0000;
        tick();
        check_eq("wrap_rel_valid", 32'(b_if.grant_valid), 32'd0);
        check_eq("wrap_rel_forced", 32'(b_if.forced_rel), 32'd0);
        b_if.req = 4'b1001;
        tick();
        check_eq("wrap_idx3", 32'(b_if.grant_idx), 32'd3);
        b_if.req = 4'b0000;
        tick();

        // Asynchronous reset mid-grant (ptr is 2 here, so 0010 wins idx 1)
        b_if.req = 4'b0010;
        tick();
        check_eq("arst_pre_grant", 32'(b_if.grant), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_grant", 32'(b_if.grant), 32'h0);
        check_eq("arst_valid", 32'(b_if.grant_valid), 32'h0);
        check_eq("arst_idx", 32'(b_if.grant_idx), 32'h0);
        tick();
        rst_n    = 1'b1;
        b_if.req = 4'b0011;
        tick();
        check_eq("arst_rr_idx", 32'(b_if.grant_idx), 32'd1);
        b_if.req = 4'b0000;
        tick();

        // rr_mode toggled during a fixed-mode grant
        a_if.rr_mode = 1'b0;
        a_if.req     = 4'b0011;
        tick();
        check_eq("tog_idx", 32'(a_if.grant_idx), 32'd1);
        a_if.rr_mode = 1'b1;
        tick();
        check_eq("tog_held_idx", 32'(a_if.grant_idx), 32'd1);
        check_eq("tog_held_valid", 32'(a_if.grant_valid), 32'd1);
        a_if.req = 4'b0001;
        tick();
        check_eq("tog_rel_valid", 32'(a_if.grant_valid), 32'd0);
        // Fixed-mode release left ptr at 3, so RR picks 1
        a_if.req = 4'b0011;
        tick();
        check_eq("tog_rr_idx1", 32'(a_if.grant_idx), 32'd1);
        a_if.req = 4'b0001;
        tick();
        check_eq("tog_rr_rel", 32'(a_if.grant_valid), 32'd0);
        // RR release of 1 moved ptr to 0, so 0 now wins over 1
        a_if.req = 4'b0011;
        tick();
        check_eq("tog_rr_idx0", 32'(a_if.grant_idx), 32'd0);
        check_eq("tog_rr_grant0", 32'(a_if.grant), 32'h1);
        a_if.req     = 4'b0000;
        a_if.rr_mode = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
